// File: rtl/addr_pipe_seg_pkg.sv
// Shared constants for the address-tracking pipe segment: default widths,
// default depth and the stage indices of the EX/MEM/WB segment.
package addr_pipe_seg_pkg;

   localparam int DEF_NSRC  = 2;
   localparam int DEF_RW    = 5;
   localparam int DEF_CW    = 12;
   localparam int DEF_DEPTH = 3;

   localparam int STG_EX  = 0;
   localparam int STG_MEM = 1;
   localparam int STG_WB  = 2;

endpackage

// File: rtl/addr_pipe_seg_if.sv
// Bus bundle for addr_pipe_seg: ID-stage inputs, per-stage hold/clear controls
// and the registered per-stage address outputs plus forwarding hits.
interface addr_pipe_seg_if
   import addr_pipe_seg_pkg::*;
#(
   parameter int NSRC  = DEF_NSRC,
   parameter int RW    = DEF_RW,
   parameter int CW    = DEF_CW,
   parameter int DEPTH = DEF_DEPTH
);

   logic                        valid_ID;
   logic [NSRC*RW-1:0]          src_ID;
   logic [RW-1:0]               dest_ID;
   logic [CW-1:0]               csr_dest_ID;
   logic [DEPTH-1:0]            bubble;
   logic [DEPTH-1:0]            flush;
   logic [NSRC*RW-1:0]          src_EX;
   logic [DEPTH-1:0]            valid_st;
   logic [DEPTH*RW-1:0]         dest_st;
   logic [DEPTH*CW-1:0]         csr_dest_st;
   logic [NSRC*(DEPTH-1)-1:0]   fwd_hit;

   modport master (
      output valid_ID, src_ID, dest_ID, csr_dest_ID, bubble, flush,
      input  src_EX, valid_st, dest_st, csr_dest_st, fwd_hit
   );

   modport slave (
      input  valid_ID, src_ID, dest_ID, csr_dest_ID, bubble, flush,
      output src_EX, valid_st, dest_st, csr_dest_st, fwd_hit
   );

endinterface

// File: rtl/addr_seg_stage.sv
// One pipe segment stage: hold on bubble, clear on flush, insert a bubble when
// the upstream stage is held, otherwise load. CSR tracking needs ADDR_PIPE_CSR_EN.
module addr_seg_stage #(
   parameter int RW        = 5,
   parameter int CW        = 12,
   parameter int SW        = 10,
   parameter bit CARRY_SRC = 1'b0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          hold,
   input  logic          clr,
   input  logic          up_hold,
   input  logic          ld_valid,
   input  logic [SW-1:0] ld_src,
   input  logic [RW-1:0] ld_dest,
   input  logic [CW-1:0] ld_csr,
   output logic          valid,
   output logic [SW-1:0] src,
   output logic [RW-1:0] dest,
   output logic [CW-1:0] csr
);

   // Any reason not to take a real entry collapses to "load all-zero".
   logic kill;
   logic unused_ld;

   assign kill      = clr | up_hold | ~ld_valid;
   assign unused_ld = ^{ld_src, ld_csr};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid <= 1'b0;
         dest  <= '0;
      end else if (!hold) begin
         valid <= ~kill;
         dest  <= kill ? '0 : ld_dest;
      end
   end

   generate
      if (CARRY_SRC) begin : g_src
         always_ff @(posedge clk) begin
            if (!rst_n)     src <= '0;
            else if (!hold) src <= kill ? '0 : ld_src;
         end
      end else begin : g_nosrc
         assign src = '0;
      end
   endgenerate

`ifdef ADDR_PIPE_CSR_EN
   always_ff @(posedge clk) begin
      if (!rst_n)     csr <= '0;
      else if (!hold) csr <= kill ? '0 : ld_csr;
   end
`else
   assign csr = '0;
`endif

endmodule

// File: rtl/addr_pipe_seg.sv
// Destination/source address tracking across the EX..WB segment with
// forwarding-hit detection. CSR tracking is enabled by ADDR_PIPE_CSR_EN.
module addr_pipe_seg
   import addr_pipe_seg_pkg::*;
#(
   parameter int NSRC  = DEF_NSRC,
   parameter int RW    = DEF_RW,
   parameter int CW    = DEF_CW,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic            clk,
   input  logic            rst_n,
   addr_pipe_seg_if.slave  bus
);

   logic [DEPTH-1:0]          valid_q;
   logic [DEPTH*RW-1:0]       dest_q;
   logic [DEPTH*CW-1:0]       csr_q;
   logic [NSRC*RW-1:0]        src_q;
   logic [NSRC*(DEPTH-1)-1:0] fwd;

   generate
      for (genvar k = 0; k < DEPTH; k++) begin : g_stage
         if (k == STG_EX) begin : g_ex
            addr_seg_stage #(.RW(RW), .CW(CW), .SW(NSRC*RW), .CARRY_SRC(1'b1)) u_stage (
               .clk      (clk),
               .rst_n    (rst_n),
               .hold     (bus.bubble[k]),
               .clr      (bus.flush[k]),
               .up_hold  (1'b0),
               .ld_valid (bus.valid_ID),
               .ld_src   (bus.src_ID),
               .ld_dest  (bus.dest_ID),
               .ld_csr   (bus.csr_dest_ID),
               .valid    (valid_q[k]),
               .src      (src_q),
               .dest     (dest_q[k*RW +: RW]),
               .csr      (csr_q[k*CW +: CW])
            );
         end else begin : g_late
            // Sources only live in EX; later stages expose a constant zero here.
            logic [NSRC*RW-1:0] src_nc;
            logic               unused_src;
            assign unused_src = ^src_nc;

            addr_seg_stage #(.RW(RW), .CW(CW), .SW(NSRC*RW), .CARRY_SRC(1'b0)) u_stage (
               .clk      (clk),
               .rst_n    (rst_n),
               .hold     (bus.bubble[k]),
               .clr      (bus.flush[k]),
               .up_hold  (bus.bubble[k-1]),
               .ld_valid (valid_q[k-1]),
               .ld_src   ('0),
               .ld_dest  (dest_q[(k-1)*RW +: RW]),
               .ld_csr   (csr_q[(k-1)*CW +: CW]),
               .valid    (valid_q[k]),
               .src      (src_nc),
               .dest     (dest_q[k*RW +: RW]),
               .csr      (csr_q[k*CW +: CW])
            );
         end
      end
   endgenerate

   // Register 0 is never a real producer, so a zero destination never hits.
   always_comb begin
      fwd = '0;
      for (int i = 0; i < NSRC; i++) begin
         for (int k = 1; k < DEPTH; k++) begin
            fwd[i*(DEPTH-1) + (k-1)] = valid_q[STG_EX] && valid_q[k]
                                       && (dest_q[k*RW +: RW] != '0)
                                       && (src_q[i*RW +: RW] == dest_q[k*RW +: RW]);
         end
      end
   end

   assign bus.src_EX      = src_q;
   assign bus.valid_st    = valid_q;
   assign bus.dest_st     = dest_q;
   assign bus.csr_dest_st = csr_q;
   assign bus.fwd_hit     = fwd;

endmodule

// File: doc/addr_pipe_seg.md
ADDR_PIPE_SEG -- requirements
Module: addr_pipe_seg

Interface
REQ-001 Parameter NSRC, default 2, number of source-register address channels.
REQ-002 Parameter RW, default 5, register address width.
REQ-003 Parameter CW, default 12, CSR address width.
REQ-004 Parameter DEPTH, default 3, number of segment stages (stage 0 = EX, 1 = MEM, 2 = WB); legal range 2..8.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 valid_ID  input  1  ID-stage instruction valid.
REQ-008 src_ID  input  NSRC*RW  packed ID-stage source addresses, channel i at bits [i*RW +: RW].
REQ-009 dest_ID  input  RW  ID-stage destination register address.
REQ-010 csr_dest_ID  input  CW  ID-stage destination CSR address.
REQ-011 bubble  input  DEPTH  per-stage hold; bit k holds stage k.
REQ-012 flush  input  DEPTH  per-stage clear; bit k clears stage k.
REQ-013 src_EX  output  NSRC*RW  stage-0 source addresses.
REQ-014 valid_st  output  DEPTH  per-stage valid.
REQ-015 dest_st  output  DEPTH*RW  per-stage destination addresses, stage k at [k*RW +: RW].
REQ-016 csr_dest_st  output  DEPTH*CW  per-stage destination CSR addresses.
REQ-017 fwd_hit  output  NSRC*(DEPTH-1)  bit i*(DEPTH-1)+(k-1) set when channel i of src_EX matches dest of stage k, k >= 1.

Function
REQ-018 Stage k update priority SHALL be: reset, then bubble[k] (hold all fields), then flush[k] (clear all fields to 0), then load.
REQ-019 bubble[k] SHALL take precedence over flush[k]: both high holds stage k unchanged.
REQ-020 Stage 0 load SHALL capture src_ID, dest_ID, csr_dest_ID, valid_ID; when valid_ID = 0 all stage-0 fields SHALL load 0.
REQ-021 Stage k >= 1 load SHALL capture stage k-1 dest, CSR and valid when bubble[k-1] = 0.
REQ-022 When bubble[k-1] = 1 and bubble[k] = 0, stage k SHALL load a bubble (all fields 0) so the held instruction is not duplicated.
REQ-023 Sources SHALL be carried in stage 0 only; latency ID to EX is one cycle, EX to stage k is k further cycles absent bubbles.
REQ-024 fwd_hit bit SHALL be 1 only if valid_st[0] = 1, valid_st[k] = 1, dest_st[k] != 0 and src channel i equals dest_st[k]; computed combinationally from registered state.
REQ-025 A flush of stage k SHALL NOT affect any other stage in the same cycle.
REQ-026 Simultaneous bubble on all stages SHALL freeze the whole pipe; release resumes with no lost or duplicated entries.

Reset
REQ-027 With rst_n = 0 at a rising edge, every stage SHALL clear valid, src, dest and CSR fields to 0 regardless of bubble and flush.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight entries; first load after release follows REQ-018..022.
REQ-029 All outputs SHALL read 0 (fwd_hit all 0) in the cycle after reset.

Configuration
REQ-030 Macro ADDR_PIPE_CSR_EN defined: CSR fields tracked through all stages per REQ-018..022.
REQ-031 Macro ADDR_PIPE_CSR_EN undefined: no CSR flops instantiated, csr_dest_ID ignored, csr_dest_st tied to 0; port list unchanged.

Structure
REQ-032 Shared package SHALL hold default RW, CW, NSRC, DEPTH constants and the stage-index constants STG_EX, STG_MEM, STG_WB.
REQ-033 One sub-module addr_seg_stage SHALL implement a single stage (hold/clear/load/bubble-insert), instantiated DEPTH times via generate.
REQ-034 Comparator logic for fwd_hit SHALL reside in the top module.

Verification
REQ-035 Reset: rst_n = 0 with valid_ID = 1, dest_ID = 5 -> after edge valid_st = 0, dest_st = 0, fwd_hit = 0.
REQ-036 Flow: issue dest 3, 4, 6 on consecutive cycles, no bubble -> cycle 3 dest_st = {6,4,3} for stages {0,1,2}, valid_st = 3'b111.
REQ-037 Forwarding: stage 1 dest = 7 valid, src_EX ch0 = 7 -> fwd_hit bit 0 = 1; same with dest = 0 -> 0.
REQ-038 Bubble insert: bubble = 3'b001 one cycle with stage 0 dest 9 -> stage 0 still 9, stage 1 valid 0 dest 0, stage 2 gets prior stage-1 entry.
REQ-039 Priority: bubble[1] = flush[1] = 1 with stage 1 dest 4 -> stage 1 holds 4 and valid 1; next cycle flush[1] alone -> stage 1 dest 0, valid 0.
REQ-040 Config: build without ADDR_PIPE_CSR_EN, csr_dest_ID = 12'h300 -> csr_dest_st stays 0; with macro -> 12'h300 at stage 0 after one cycle.
